// File: rtl/encoder_seq.sv
// Sequential priority encoder: captures request lines into a sticky pending
// register and serves one encoded index at a time over a valid/ready handshake.
module encoder_seq #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       e,
  input  logic       ready,
  output logic [2:0] a,
  output logic       valid,
  output logic [7:0] pend,
  output logic       any
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] a_q, a_d;
  logic       valid_q, valid_d;
  logic       transfer;
  logic [7:0] clr_mask;
  logic [2:0] sel;

  // Fixed-priority encode; the later match in the scan wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  assign transfer = valid_q & ready;
  assign clr_mask = transfer ? (8'b1 << a_q) : 8'b0;
  assign sel      = prio_enc(pend_q);

  // Set is OR-ed in after the clear, so a same-edge re-request wins.
  assign pend_d = (pend_q & ~clr_mask) | (e ? d : 8'b0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          a_d     = sel;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      valid_q <= valid_d;
    end
  end

  assign a     = a_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign any   = |pend_q;

endmodule

// File: doc/encoder_seq.md
ENCODER_SEQ -- requirements
Module: encoder_seq

Interface
REQ-001 Parameter PRIO_HIGH, default 1, meaning: 1 = bit 7 of d has highest priority; 0 = bit 0 has highest priority.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 d  input  8  request lines, one per source, level-sampled at each rising edge.
REQ-005 e  input  1  capture enable; d is sampled only while e=1.
REQ-006 ready  input  1  consumer accepts the current code.
REQ-007 a  output  3  encoded index of the served request, registered.
REQ-008 valid  output  1  a holds a pending code, registered.
REQ-009 pend  output  8  pending-request register, registered.
REQ-010 any  output  1  combinational OR of pend.

Function
REQ-011 Clock and reset SHALL be a single clock, clk, with reset asynchronous and active-low on rst_n.
REQ-012 Handshake: a transfer occurs at a rising edge where valid=1 and ready=1.
REQ-013 Capture: at each edge, pend[i] SHALL set when e=1 and d[i]=1; e=0 SHALL block all new captures without affecting serving.
REQ-014 Clear: at a transfer edge, pend[a] SHALL clear.
REQ-015 If capture and clear hit the same bit at the same edge, the set SHALL win and pend[i] SHALL remain 1.
REQ-016 A bit already pending SHALL absorb repeated requests with no counting and no overflow.
REQ-017 FSM states are IDLE and HOLD; after reset the FSM SHALL be in IDLE.
REQ-018 IDLE with pend != 0: at the next edge, a SHALL load the highest-priority set index of pend, valid SHALL go to 1, and the FSM SHALL move to HOLD.
REQ-019 IDLE with pend == 0: the FSM SHALL stay in IDLE with valid=0, and a SHALL hold its last value.
REQ-020 HOLD without ready: a and valid SHALL remain stable, even if a higher-priority request arrives meanwhile.
REQ-021 HOLD with ready: the transfer occurs, valid SHALL go to 0, and the FSM SHALL return to IDLE, giving one bubble cycle and a maximum of one code per 2 cycles.
REQ-022 Latency: a request sampled at edge N SHALL make pend visible after edge N; if the FSM is in IDLE, valid and a SHALL be visible after edge N+1.
REQ-023 Arbitration SHALL use pend as registered, not raw d.
REQ-024 Priority selection SHALL be a fixed priority encode per PRIO_HIGH; for PRIO_HIGH=1 with pend=8'b0010_0100, a=5.
REQ-025 ready while valid=0 SHALL be ignored.
REQ-026 any SHALL equal |pend at all times, including during reset.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force pend=0, a=0, valid=0, any=0, and FSM=IDLE.
REQ-028 Reset asserted while in HOLD SHALL discard the in-flight code and all pending requests.
REQ-029 After rst_n rises, the first capture SHALL occur at the first rising edge with e=1.
REQ-030 No output SHALL be X after reset.

Verification
REQ-031 Single request, PRIO_HIGH=1: e=1, d=8'h01 for one edge, ready=1 -> pend=8'h01, next edge valid=1 a=0, next edge valid=0 pend=0.
REQ-032 All sources, one at a time: d sweeps one-hot 8'h01..8'h80, each followed by a transfer -> a runs 0..7 in order.
REQ-033 Priority order, PRIO_HIGH=1: d=8'hFF for one edge, ready=1 -> a sequence 7,6,5,4,3,2,1,0, valid toggling 1/0, any=0 after the 8th transfer.
REQ-034 Priority order, PRIO_HIGH=0: same stimulus as REQ-033 -> a sequence 0..7.
REQ-035 Backpressure and enable: valid=1 a=3 with ready=0 for 5 cycles while d=8'h80 arrives -> a stays 3; after the transfer, a=7 is served next; with e=0, d=8'hFF -> pend unchanged.
REQ-036 Set/clear collision and reset: re-request bit 3 on its transfer edge -> pend[3]=1, a=3 again; rst_n pulsed low mid-HOLD -> valid=0, pend=0, any=0 asynchronously.
